// File: rtl/if_prefetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_buf
// Description : Instruction-fetch stage with a DEPTH-entry prefetch FIFO and
//               branch-redirect squash of in-flight fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_buf #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       br,
    input  logic [ADDR_W-1:0]          br_target,
    input  logic                       id_stall,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_done,
    input  logic [INST_W-1:0]          mem_rdata,
    output logic [ADDR_W-1:0]          pc_o,
    output logic [INST_W-1:0]          inst_o,
    output logic                       valid_o,
    output logic                       if_stallreq,
    output logic                       cancel,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam int                LVL_W    = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   fetch_pc_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [ADDR_W-1:0]   seq_pc;
    logic [LVL_W-1:0]    level_nxt;
    logic                push;
    logic                pop;

    logic [ADDR_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0]   inst_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // Redirect wins over both FIFO ports; a response is only kept in WAIT.
    assign pop    = valid_o & ~id_stall & ~br;
    assign push   = (state == S_WAIT) & mem_done & ~br;
    assign seq_pc = mem_addr + STEP;

    always_comb begin
        level_nxt = level + LVL_W'(push) - LVL_W'(pop);
    end

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        mem_addr_nxt = mem_addr;
        case (state)
            S_IDLE: begin
                if (br) begin
                    fetch_pc_nxt = br_target;
                end else if (level < FULL_LVL) begin
                    state_nxt    = S_WAIT;
                    mem_addr_nxt = fetch_pc;
                end
            end
            S_WAIT: begin
                if (br) begin
                    fetch_pc_nxt = br_target;
                    state_nxt    = mem_done ? S_IDLE : S_DROP;
                end else if (mem_done) begin
                    fetch_pc_nxt = seq_pc;
                    if (level_nxt < FULL_LVL) begin
                        mem_addr_nxt = seq_pc;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                // A redirect landing on the squashed response itself leaves
                // nothing outstanding, so fall back to IDLE and reissue.
                if (br) begin
                    fetch_pc_nxt = br_target;
                    if (mem_done) begin
                        state_nxt = S_IDLE;
                    end
                end else if (mem_done) begin
                    state_nxt    = S_WAIT;
                    mem_addr_nxt = fetch_pc;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            mem_addr <= mem_addr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (br) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            level <= level_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= mem_addr;
            inst_mem[wr_ptr] <= mem_rdata;
        end
    end

    assign mem_req     = (state != S_IDLE);
    assign valid_o     = (level != '0);
    assign pc_o        = valid_o ? pc_mem[rd_ptr]   : '0;
    assign inst_o      = valid_o ? inst_mem[rd_ptr] : '0;
    assign if_stallreq = ~valid_o & ~br;
    assign cancel      = br;

endmodule
`default_nettype wire
